// File: rtl/divn_seq.sv
// Serial remainder unit: restoring shift/subtract, one dividend bit per clock, MSB first.
// Reports remainder, divisible flag and divide-by-zero error over a valid/ready handshake.
module divn_seq #(
    parameter int IN_WIDTH  = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIV_WIDTH-1:0] rem,
    output logic                 ans,
    output logic                 err
);

    localparam int            CW   = $clog2(IN_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(IN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [IN_WIDTH-1:0]  data_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] r_q;
    logic [DIV_WIDTH-1:0] r_d;
    logic [DIV_WIDTH-1:0] rem_q;
    logic                 ans_q;
    logic                 err_q;
    logic [DIV_WIDTH:0]   t;

    // r stays below the divisor, so the low DIV_WIDTH bits of t - divisor are exact
    always_comb begin
        t   = {r_q, data_q[IN_WIDTH-1]};
        r_d = t[DIV_WIDTH-1:0];
        if (t >= {1'b0, div_q})
            r_d = t[DIV_WIDTH-1:0] - div_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            div_q   <= '0;
            r_q     <= '0;
            rem_q   <= '0;
            ans_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q <= data;
                        div_q  <= divisor;
                        r_q    <= '0;
                        cnt_q  <= '0;
                        if (divisor == '0) begin
                            state_q <= DONE;
                            rem_q   <= '0;
                            ans_q   <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_q    <= r_d;
                    data_q <= {data_q[IN_WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        rem_q   <= r_d;
                        ans_q   <= (r_d == '0);
                        err_q   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign rem       = rem_q;
    assign ans       = ans_q;
    assign err       = err_q;

endmodule

// File: tb/tb_divn_seq.sv
// Self-checking bench for divn_seq: directed plan vectors plus randomized ops
// compared against a plain modulo reference model.
module tb_divn_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  rem;
    logic        ans;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    divn_seq #(.IN_WIDTH(16), .DIV_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .rem(rem), .ans(ans), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain modulo arithmetic.
    function automatic logic [7:0] m_rem(input logic [15:0] d, input logic [7:0] v);
        if (v == 8'd0) return 8'd0;
        return 8'(d % 16'(v));
    endfunction
    function automatic logic m_ans(input logic [15:0] d, input logic [7:0] v);
        return (v != 8'd0) && ((d % 16'(v)) == 16'd0);
    endfunction
    function automatic int m_lat(input logic [7:0] v);
        return (v == 8'd0) ? 1 : 17;
    endfunction

    // Accepts one pair, scrambles the inputs afterwards, and waits for out_valid.
    task automatic do_op(input logic [15:0] d, input logic [7:0] v,
                         output logic [7:0] r, output logic a, output logic e, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin tick(); guard++; end
        data = d; divisor = v; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data = 16'($urandom); divisor = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin tick(); lat++; end
        r = rem; a = ans; e = err;
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
        else n_pass++;
        n_chk++;
        if (rem !== 8'd0 || ans !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_out: rem=%0d ans=%b err=%b required 0 0 0", rem, ans, err);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_plan();
        logic [15:0] dv[6] = '{16'd65535, 16'd65535, 16'd12348, 16'd64, 16'd15, 16'd0};
        logic [7:0]  vv[6] = '{8'd3, 8'd255, 8'd7, 8'd7, 8'd4, 8'd5};
        logic [7:0] r; logic a, e; int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(dv[i], vv[i], r, a, e, lat);
            n_chk++;
            if (lat != 17)
                $display("FAIL plan_lat[%0d]: latency=%0d required 17", i, lat);
            else n_pass++;
            n_chk++;
            if (r !== m_rem(dv[i], vv[i]) || a !== m_ans(dv[i], vv[i]) || e !== 1'b0)
                $display("FAIL plan_res[%0d] %0d mod %0d: rem=%0d ans=%b err=%b required %0d %b 0",
                         i, dv[i], vv[i], r, a, e, m_rem(dv[i], vv[i]), m_ans(dv[i], vv[i]));
            else n_pass++;
            release_op();
        end
    endtask

    task automatic test_div2();
        logic [15:0] dv[7] = '{16'd65535, 16'd12348, 16'd64, 16'd32, 16'd15, 16'd6, 16'd0};
        logic        ea[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] r; logic a, e; int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(dv[i], 8'd2, r, a, e, lat);
            n_chk++;
            if (a !== ea[i] || r !== {7'd0, ~ea[i]} || e !== 1'b0)
                $display("FAIL div2[%0d] data=%0d: ans=%b rem=%0d err=%b required %b %0d 0",
                         i, dv[i], a, r, e, ea[i], {7'd0, ~ea[i]});
            else n_pass++;
            release_op();
        end
    endtask

    task automatic test_div0();
        logic [7:0] r; logic a, e; int lat;
        do_op(16'd100, 8'd0, r, a, e, lat);
        n_chk++;
        if (lat != 1)
            $display("FAIL div0_lat: latency=%0d required 1", lat);
        else n_pass++;
        n_chk++;
        if (e !== 1'b1 || a !== 1'b0 || r !== 8'd0)
            $display("FAIL div0_res: err=%b ans=%b rem=%0d required 1 0 0", e, a, r);
        else n_pass++;
        release_op();
        do_op(16'd100, 8'd10, r, a, e, lat);
        n_chk++;
        if (e !== 1'b0 || a !== 1'b1 || r !== 8'd0 || lat != 17)
            $display("FAIL div0_next: err=%b ans=%b rem=%0d lat=%0d required 0 1 0 17", e, a, r, lat);
        else n_pass++;
        release_op();
    endtask

    task automatic test_backpressure();
        logic [7:0] r; logic a, e; int lat; int bad = 0;
        do_op(16'd1000, 8'd7, r, a, e, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; data = 16'($urandom); divisor = 8'($urandom);
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || rem !== m_rem(16'd1000, 8'd7)
                || ans !== 1'b0 || err !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_chk++;
        if (bad != 0)
            $display("FAIL bp_hold: %0d unstable cycles, required 0 (rem=%0d exp %0d)",
                     bad, rem, m_rem(16'd1000, 8'd7));
        else n_pass++;
        release_op();
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] r; logic a, e; int lat; int pulses = 0;
        data = 16'd1000; divisor = 8'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (rem !== 8'd0 || ans !== 1'b0 || err !== 1'b0)
            $display("FAIL rstmid_out: rem=%0d ans=%b err=%b required 0 0 0", rem, ans, err);
        else n_pass++;
        for (int i = 0; i < 25; i++) begin
            if (out_valid !== 1'b0) pulses++;
            tick();
        end
        n_chk++;
        if (pulses != 0)
            $display("FAIL rstmid_pulse: out_valid high %0d cycles, required 0", pulses);
        else n_pass++;
        do_op(16'd1000, 8'd9, r, a, e, lat);
        n_chk++;
        if (r !== 8'd1 || a !== 1'b0 || e !== 1'b0 || lat != 17)
            $display("FAIL rstmid_fresh: rem=%0d ans=%b err=%b lat=%0d required 1 0 0 17", r, a, e, lat);
        else n_pass++;
        release_op();
    endtask

    task automatic test_random();
        logic [7:0] r; logic a, e; int lat;
        logic [15:0] d; logic [7:0] v;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_op(d, v, r, a, e, lat);
            n_chk++;
            if (r !== m_rem(d, v) || a !== m_ans(d, v) || e !== (v == 8'd0) || lat != m_lat(v))
                $display("FAIL rand[%0d] %0d mod %0d: rem=%0d ans=%b err=%b lat=%0d required %0d %b %b %0d",
                         i, d, v, r, a, e, lat, m_rem(d, v), m_ans(d, v), (v == 8'd0), m_lat(v));
            else n_pass++;
            for (int k = $urandom_range(0, 3); k > 0; k--) tick();
            release_op();
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_div2();
        test_div0();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
